// File: rtl/xgriscv_wb_stage.sv
// MEM/WB pipeline register and writeback datapath: load alignment/extension,
// writeback source select, regfile write port and retired-instruction counter.
module xgriscv_wb_stage #(
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int ADDR_SIZE   = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   m_valid,
  input  logic [ADDR_SIZE-1:0]   m_pc,
  input  logic                   m_regwrite,
  input  logic [RFIDX_WIDTH-1:0] m_rd,
  input  logic [1:0]             m_wbsel,
  input  logic [XLEN-1:0]        m_aluout,
  input  logic [XLEN-1:0]        m_memdata,
  input  logic [2:0]             m_funct3,
  output logic                   write,
  output logic [RFIDX_WIDTH-1:0] writeaddress,
  output logic [XLEN-1:0]        writedata,
  output logic [ADDR_SIZE-1:0]   pc,
  output logic                   wb_valid,
  output logic [63:0]            instret
);

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_ALU2 = 2'b11
  } wbsel_e;

  logic [7:0]           load_byte;
  logic [15:0]          load_half;
  logic [XLEN-1:0]      load_data;
  logic [ADDR_SIZE-1:0] pc_plus4;
  logic [XLEN-1:0]      wb_result;
  logic                 wb_write;

  assign load_half = m_aluout[1] ? m_memdata[31:16] : m_memdata[15:0];
  assign pc_plus4  = m_pc + ADDR_SIZE'(4);
  assign wb_write  = m_valid & m_regwrite & (m_rd != '0);

  // NOTE: every always_comb output gets a default before the case so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    load_byte = m_memdata[7:0];
    case (m_aluout[1:0])
      2'd1:    load_byte = m_memdata[15:8];
      2'd2:    load_byte = m_memdata[23:16];
      2'd3:    load_byte = m_memdata[31:24];
      default: load_byte = m_memdata[7:0];
    endcase
  end

  // Reserved load encodings fall through to the raw word, same as LW.
  always_comb begin
    load_data = m_memdata;
    case (load_f3_e'(m_funct3))
      F3_LB:   load_data = {{(XLEN-8){load_byte[7]}}, load_byte};
      F3_LH:   load_data = {{(XLEN-16){load_half[15]}}, load_half};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, load_byte};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, load_half};
      default: load_data = m_memdata;
    endcase
  end

  always_comb begin
    wb_result = m_aluout;
    case (wbsel_e'(m_wbsel))
      WB_LOAD: wb_result = load_data;
      WB_PC4:  wb_result = XLEN'(pc_plus4);
      default: wb_result = m_aluout;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; reset is synchronous and outranks flush/stall.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wb_valid     <= 1'b0;
      write        <= 1'b0;
      writeaddress <= '0;
      writedata    <= '0;
      pc           <= '0;
      instret      <= '0;
    end else begin
      // An entry retires when it leaves WB, so a stalled entry counts once.
      if (wb_valid && !stall) instret <= instret + 64'd1;

      if (flush) begin
        wb_valid <= 1'b0;
        write    <= 1'b0;
      end else if (!stall) begin
        wb_valid     <= m_valid;
        write        <= wb_write;
        writeaddress <= m_rd;
        writedata    <= wb_result;
        pc           <= m_pc;
      end
    end
  end

endmodule

// File: tb/tb_xgriscv_wb_stage.sv
// Scoreboarded bench for xgriscv_wb_stage: directed cases plus random traffic
// against a spec-level model of the WB register contents.
module tb_xgriscv_wb_stage;

  logic        clk = 1'b0;
  logic        rstn, stall, flush, m_valid, m_regwrite;
  logic [31:0] m_pc, m_aluout, m_memdata;
  logic [4:0]  m_rd;
  logic [1:0]  m_wbsel;
  logic [2:0]  m_funct3;
  logic        write, wb_valid;
  logic [4:0]  writeaddress;
  logic [31:0] writedata, pc;
  logic [63:0] instret;

  always #5 clk = ~clk;

  xgriscv_wb_stage dut (
    .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_pc(m_pc), .m_regwrite(m_regwrite), .m_rd(m_rd),
    .m_wbsel(m_wbsel), .m_aluout(m_aluout), .m_memdata(m_memdata),
    .m_funct3(m_funct3), .write(write), .writeaddress(writeaddress),
    .writedata(writedata), .pc(pc), .wb_valid(wb_valid), .instret(instret)
  );

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [63:0] instret;
  } wb_state_t;

  wb_state_t model;
  wb_state_t expq[$];
  int        checks   = 0;
  int        failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Load result from the architectural rules: shift the wanted lane down, then extend.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] data);
    logic [31:0] b, h;
    b = (data >> (8 * addr[1:0])) & 32'hFF;
    h = (data >> (16 * addr[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (m_wbsel)
      2'b01:   return ref_load(m_funct3, m_aluout, m_memdata);
      2'b10:   return m_pc + 32'd4;
      default: return m_aluout;
    endcase
  endfunction

  // Monitor: the DUT presents a new WB state every edge; compare it just after.
  always @(posedge clk) begin
    wb_state_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      check("wb_valid", 64'(wb_valid), 64'(e.valid));
      check("write", 64'(write), 64'(e.write));
      check("instret", instret, e.instret);
      if (e.valid) begin
        check("writeaddress", 64'(writeaddress), 64'(e.waddr));
        check("writedata", 64'(writedata), 64'(e.wdata));
        check("pc", 64'(pc), 64'(e.pc));
      end
    end
  end

  // Called just after a negedge with inputs set; predicts the next edge's result.
  task automatic cycle(input bit use_exp = 1'b0, input logic [31:0] exp_data = '0);
    wb_state_t n;
    n = model;
    if (!rstn) begin
      n = '0;
    end else begin
      if (model.valid && !stall) n.instret = model.instret + 64'd1;
      if (flush) begin
        n.valid = 1'b0;
        n.write = 1'b0;
      end else if (!stall) begin
        n.valid = m_valid;
        n.write = m_valid && m_regwrite && (m_rd != 5'd0);
        n.waddr = m_rd;
        n.pc    = m_pc;
        n.wdata = use_exp ? exp_data : ref_result();
      end
    end
    model = n;
    expq.push_back(n);
    @(negedge clk);
  endtask

  task automatic set_instr(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                           input logic [31:0] pcv);
    m_valid = 1'b1; m_regwrite = 1'b1; m_rd = rd; m_wbsel = sel;
    m_aluout = alu; m_pc = pcv; m_funct3 = 3'b010; m_memdata = 32'h0;
  endtask

  task automatic randomize_inputs();
    m_valid    = 1'($urandom);
    m_regwrite = 1'($urandom);
    m_rd       = 5'($urandom);
    m_wbsel    = 2'($urandom);
    m_aluout   = $urandom;
    m_memdata  = $urandom;
    m_funct3   = 3'($urandom);
    m_pc       = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp);
    set_instr(5'd7, 2'b01, {30'h0400_0000, lo}, 32'h200);
    m_funct3  = f3;
    m_memdata = 32'h80FF_7F01;
    cycle(1'b1, exp);
  endtask

  initial begin
    int guard;
    model = '0;
    rstn = 1'b0; stall = 1'b1; flush = 1'b0;
    set_instr(5'd3, 2'b00, 32'hDEAD_BEEF, 32'h40);
    @(negedge clk);

    // Reset wins over stall with a valid instruction presented.
    cycle(); cycle();
    rstn = 1'b1; stall = 1'b0;

    // ALU writeback, then a bubble so the retirement shows up.
    set_instr(5'd5, 2'b00, 32'h1234_5678, 32'h100);
    cycle(1'b1, 32'h1234_5678);
    m_valid = 1'b0;
    cycle();

    do_load(3'b000, 2'd3, 32'hFFFF_FF80);
    do_load(3'b100, 2'd1, 32'h0000_007F);
    do_load(3'b001, 2'd2, 32'hFFFF_80FF);
    do_load(3'b101, 2'd0, 32'h0000_7F01);
    do_load(3'b010, 2'd0, 32'h80FF_7F01);
    do_load(3'b001, 2'd3, 32'hFFFF_80FF);
    do_load(3'b111, 2'd2, 32'h80FF_7F01);

    // JAL link wraps; then rd=x0 suppresses the write but still retires.
    set_instr(5'd1, 2'b10, 32'h0, 32'hFFFF_FFFC);
    cycle(1'b1, 32'h0);
    set_instr(5'd0, 2'b10, 32'h0, 32'hFFFF_FFFC);
    cycle(1'b1, 32'h0);

    // Entry A held through a 3-cycle stall while inputs churn.
    set_instr(5'd9, 2'b11, 32'hA5A5_0001, 32'h300);
    cycle(1'b1, 32'hA5A5_0001);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      cycle();
    end
    stall = 1'b0; m_valid = 1'b0;
    cycle();

    // Stall and flush together on a valid entry: bubble, no count.
    set_instr(5'd10, 2'b00, 32'h0BAD_F00D, 32'h400);
    cycle();
    stall = 1'b1; flush = 1'b1;
    cycle();
    stall = 1'b0; flush = 1'b0; m_valid = 1'b0;
    cycle();

    // Counter wrap: deposit all-ones, then retire one instruction.
    set_instr(5'd11, 2'b00, 32'h1, 32'h500);
    cycle();
    dut.instret   = 64'hFFFF_FFFF_FFFF_FFFF;
    model.instret = 64'hFFFF_FFFF_FFFF_FFFF;
    m_valid = 1'b0;
    cycle();

    // Reset while stalled discards the held entry.
    set_instr(5'd12, 2'b00, 32'h77, 32'h600);
    cycle();
    stall = 1'b1; rstn = 1'b0;
    cycle();
    stall = 1'b0; rstn = 1'b1;

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      rstn  = ($urandom_range(0, 59) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end

    guard = 0;
    while (expq.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("scoreboard_drain", 64'(expq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xgriscv_wb_stage.md
Name: xgriscv_wb_stage

Overview:
- MEM/WB pipeline register plus writeback datapath.
- Captures the memory-stage result, aligns and sign/zero-extends load data, selects the writeback source, and drives the regfile write port (write, writeaddress, writedata, pc).
- Also keeps a 64-bit retired-instruction counter.
- Sits directly upstream of the regfile; its outputs also serve as the WB forwarding source.

Parameters:
- XLEN, 32, datapath width
- RFIDX_WIDTH, 5, register index width
- ADDR_SIZE, 32, PC width

Ports:
- clk  input  1  core clock, rising-edge registers
- rstn  input  1  synchronous reset, active-low
- stall  input  1  hold WB contents
- flush  input  1  load bubble into WB
- m_valid  input  1  MEM-stage instruction valid
- m_pc  input  ADDR_SIZE  MEM-stage PC
- m_regwrite  input  1  instruction writes rd
- m_rd  input  RFIDX_WIDTH  destination register
- m_wbsel  input  2  00 ALU, 01 load, 10 PC+4, 11 ALU
- m_aluout  input  XLEN  ALU result / memory address
- m_memdata  input  XLEN  raw aligned word from data memory
- m_funct3  input  3  load type
- write  output  1  regfile write enable
- writeaddress  output  RFIDX_WIDTH  regfile write index
- writedata  output  XLEN  regfile write data
- pc  output  ADDR_SIZE  PC of WB instruction (for regfile trace)
- wb_valid  output  1  WB holds a valid instruction
- instret  output  64  retired-instruction count

Behaviour:
Reset:
- On a rising edge with rstn=0, all registers clear: wb_valid=0, write=0, writeaddress=0, writedata=0, pc=0, instret=0.
- Reset overrides stall and flush.
- Reset mid-stall discards the held entry.

Pipeline:
- Latency is 1 cycle. On each rising edge, priority is reset > flush > stall > load.
- flush=1: wb_valid<=0 and write<=0. Other fields are don't-care but held at their previous values.
- stall=1 with flush=0: all WB registers hold.
- Otherwise: capture wb_valid<=m_valid, writeaddress<=m_rd, pc<=m_pc, and writedata<=the computed result.
- write <= m_valid & m_regwrite & (m_rd!=0). Writes to x0 are suppressed here as well as in the regfile.

Load extraction (combinational, before the register):
- Byte select is m_aluout[1:0]; halfword select is m_aluout[1] (bit 0 ignored).
- 000 LB: sign-extend byte.
- 001 LH: sign-extend half.
- 010 LW: word.
- 100 LBU: zero-extend byte.
- 101 LHU: zero-extend half.
- 011/110/111: raw word.
- Byte k = m_memdata[8k+7:8k]; half 0 = [15:0], half 1 = [31:16].

Writeback select:
- 00/11: m_aluout
- 01: extracted load data
- 10: m_pc+4, truncated to XLEN (wraps modulo 2^XLEN)

instret:
- Increments by 1 on a rising edge where rstn=1, wb_valid=1 and stall=0, i.e. the WB entry leaves the stage.
- A stalled entry counts once.
- Flushed bubbles never count.
- Wraps from 2^64-1 to 0.
- Counts all valid instructions, including those with write=0.

Outputs:
- All outputs are registered; no combinational path from inputs to outputs.
- The regfile samples on the negedge, so data is stable for half a cycle before the write.

Test Plan:
- Reset: hold rstn=0 two cycles with m_valid=1, stall=1 -> all outputs 0, instret=0; release -> first captured entry appears one edge later.
- ALU writeback: m_valid=1, m_regwrite=1, m_rd=5, m_wbsel=00, m_aluout=0x12345678, m_pc=0x100 -> next edge write=1, writeaddress=5, writedata=0x12345678, pc=0x100; instret +1 on the following edge.
- Loads with m_memdata=0x80FF7F01:
  - LB, addr_lo=3 -> 0xFFFFFF80
  - LBU, addr_lo=1 -> 0x0000007F
  - LH, addr_lo=2 -> 0xFFFF80FF
  - LHU, addr_lo=0 -> 0x00007F01
  - LW -> 0x80FF7F01
- JAL link and x0: m_wbsel=10, m_pc=0xFFFFFFFC, m_rd=1 -> writedata=0x00000000. Repeat with m_rd=0, m_regwrite=1 -> write=0, wb_valid=1, instret still increments.
- Stall/flush:
  - Load entry A, then stall=1 for 3 cycles while inputs change -> outputs stay A, instret increments once when stall drops.
  - stall=1 and flush=1 together -> wb_valid=0, write=0, no count.
- Counter wrap: force instret=0xFFFFFFFFFFFFFFFF via hierarchical deposit, retire one instruction -> instret=0.
